fetch_unit: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the pipelined MIPS core. It is the producer side of the decode controller's interface: it supplies OPC/func from the IF/ID instruction and consumes the PC_src redirect the controller returns. It sequences requests to a variable-latency instruction memory, absorbs hazard stalls in a one-entry buffer, and flushes the wrong-path instruction on a taken branch or jump. There are no delay slots.

---
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage and IF/ID register: sequences variable-latency imem requests,
// absorbs hazard stalls in a one-entry buffer and squashes wrong-path words on redirects.
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        PC_src,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_inst,
    output logic [31:0]       IF_ID_inst,
    output logic [ADDR_W-1:0] IF_ID_pc4,
    output logic              IF_ID_valid,
    output logic [5:0]        OPC,
    output logic [5:0]        func
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_DROP  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_req;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_redir_pc;
    logic [31:0]       r_buf_inst;
    logic [ADDR_W-1:0] r_buf_pc4;
    logic [31:0]       r_inst;
    logic [ADDR_W-1:0] r_pc4;
    logic              r_valid;

    logic              w_redirect;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_pc_plus4;

    // PC_src 11 is reserved and falls through as sequential
    assign w_redirect = r_valid & ~stall & ((PC_src == 2'b01) | (PC_src == 2'b10));
    assign w_target   = (PC_src == 2'b01) ? branch_target : jump_target;
    assign w_pc_plus4 = r_pc + ADDR_W'(4);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_BOOT;
            r_req      <= 1'b0;
            r_pc       <= RESET_PC;
            r_redir_pc <= '0;
            r_buf_inst <= '0;
            r_buf_pc4  <= '0;
            r_inst     <= '0;
            r_pc4      <= '0;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                end
                S_FETCH: begin
                    if (w_redirect) begin
                        r_inst  <= '0;
                        r_valid <= 1'b0;
                        if (imem_ack) begin
                            r_pc <= w_target;
                        end else begin
                            r_redir_pc <= w_target;
                            r_state    <= S_DROP;
                        end
                    end else if (imem_ack && !stall) begin
                        r_inst  <= imem_inst;
                        r_pc4   <= w_pc_plus4;
                        r_valid <= 1'b1;
                        r_pc    <= w_pc_plus4;
                    end else if (imem_ack) begin
                        r_buf_inst <= imem_inst;
                        r_buf_pc4  <= w_pc_plus4;
                        r_pc       <= w_pc_plus4;
                        r_state    <= S_HOLD;
                        r_req      <= 1'b0;
                    end else if (!stall) begin
                        r_inst  <= '0;
                        r_valid <= 1'b0;
                    end
                end
                S_DROP: begin
                    // the in-flight word belongs to the wrong path; wait for it, then retarget
                    if (imem_ack) begin
                        r_pc    <= r_redir_pc;
                        r_state <= S_FETCH;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        if (w_redirect) begin
                            r_inst  <= '0;
                            r_valid <= 1'b0;
                            r_pc    <= w_target;
                        end else begin
                            r_inst  <= r_buf_inst;
                            r_pc4   <= r_buf_pc4;
                            r_valid <= 1'b1;
                        end
                        r_state <= S_FETCH;
                        r_req   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_BOOT;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign IF_ID_inst  = r_inst;
    assign IF_ID_pc4   = r_pc4;
    assign IF_ID_valid = r_valid;
    assign OPC         = r_inst[31:26];
    assign func        = r_inst[5:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal expectations,
// then randomized latency/stall/redirect traffic checked each cycle against a reference model.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  PC_src = 2'b00;
    logic [31:0] branch_target = '0;
    logic [31:0] jump_target = '0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_inst;
    logic [31:0] IF_ID_inst;
    logic [31:0] IF_ID_pc4;
    logic        IF_ID_valid;
    logic [5:0]  OPC;
    logic [5:0]  func;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit #(.ADDR_W(32), .RESET_PC(RPC)) dut (
        .clk           (clk),
        .rst           (rst),
        .PC_src        (PC_src),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .stall         (stall),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_inst     (imem_inst),
        .IF_ID_inst    (IF_ID_inst),
        .IF_ID_pc4     (IF_ID_pc4),
        .IF_ID_valid   (IF_ID_valid),
        .OPC           (OPC),
        .func          (func)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: a counting pattern low, a scrambled address high
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'h100) return 32'h20010005 + (a >> 2) * 32'h00010002;
        return {a[7:0], a[31:8]} ^ 32'hA5C31E0F;
    endfunction

    assign imem_inst = mem_word(imem_addr);

    // Reference model: where fetch is, what IF/ID shows, and what is parked/pending
    bit          m_booting;
    bit          m_squash_pending;
    logic [31:0] m_squash_target;
    bit          m_parked;
    logic [31:0] m_park_inst, m_park_pc4;
    logic [31:0] m_pc;
    logic [31:0] m_inst, m_pc4;
    bit          m_valid;

    task automatic model_reset();
        m_booting = 1; m_squash_pending = 0; m_parked = 0;
        m_pc = RPC; m_inst = 0; m_pc4 = 0; m_valid = 0;
        m_squash_target = 0; m_park_inst = 0; m_park_pc4 = 0;
    endtask

    function automatic bit model_req();
        return !m_booting && !m_parked;
    endfunction

    task automatic model_step(input bit ack, input bit st, input logic [1:0] src,
                              input logic [31:0] bt, input logic [31:0] jt);
        logic [31:0] word = mem_word(m_pc);
        logic [31:0] next_pc = m_pc + 32'd4;
        bit take = m_valid && !st && (src == 2'b01 || src == 2'b10);
        logic [31:0] tgt = (src == 2'b01) ? bt : jt;
        if (m_booting) begin
            m_booting = 0;
        end else if (m_squash_pending) begin
            if (ack) begin m_pc = m_squash_target; m_squash_pending = 0; end
        end else if (m_parked) begin
            if (!st) begin
                m_parked = 0;
                if (take) begin m_inst = 0; m_valid = 0; m_pc = tgt; end
                else begin m_inst = m_park_inst; m_pc4 = m_park_pc4; m_valid = 1; end
            end
        end else if (take) begin
            m_inst = 0; m_valid = 0;
            if (ack) m_pc = tgt;
            else begin m_squash_pending = 1; m_squash_target = tgt; end
        end else if (ack) begin
            if (st) begin m_parked = 1; m_park_inst = word; m_park_pc4 = next_pc; end
            else begin m_inst = word; m_pc4 = next_pc; m_valid = 1; end
            m_pc = next_pc;
        end else if (!st) begin
            m_inst = 0; m_valid = 0;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("imem_req", 32'(imem_req), 32'(model_req()));
        if (model_req()) chk("imem_addr", imem_addr, m_pc);
        chk("IF_ID_inst", IF_ID_inst, m_inst);
        chk("IF_ID_pc4", IF_ID_pc4, m_pc4);
        chk("IF_ID_valid", 32'(IF_ID_valid), 32'(m_valid));
        chk("OPC", 32'(OPC), 32'(m_inst[31:26]));
        chk("func", 32'(func), 32'(m_inst[5:0]));
    endtask

    task automatic cycle(input bit ack, input bit st, input logic [1:0] src,
                         input logic [31:0] bt, input logic [31:0] jt);
        imem_ack = ack; stall = st; PC_src = src; branch_target = bt; jump_target = jt;
        model_step(ack, st, src, bt, jt);
        @(posedge clk);
        @(negedge clk);
        $display("cyc ack=%0d stall=%0d src=%0d req=%0d addr=%08h if_id=%08h pc4=%08h v=%0d",
                 ack, st, src, imem_req, imem_addr, IF_ID_inst, IF_ID_pc4, IF_ID_valid);
        compare_all();
    endtask

    // Asynchronous reset mid-cycle, with a stale ack on the bus throughout
    task automatic do_reset();
        #2 rst = 1'b0;
        imem_ack = 1'b1;
        #1;
        model_reset();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(IF_ID_valid), 32'd0);
        chk("rst_inst", IF_ID_inst, 32'd0);
        chk("rst_pc4", IF_ID_pc4, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        $display("reset pulse done");
    endtask

    int  lat;
    bit  lat_on;
    bit  r_ack, r_st;
    logic [1:0]  r_src;
    logic [31:0] r_bt, r_jt;

    initial begin
        model_reset();
        @(negedge clk);
        compare_all();
        rst = 1'b1;

        // Zero-wait streaming from reset
        cycle(0, 0, 2'b00, 0, 0);
        chk("lit_first_addr", imem_addr, 32'h0);
        chk("lit_first_valid", 32'(IF_ID_valid), 32'd0);
        cycle(1, 0, 2'b00, 0, 0);
        chk("lit_addr4", imem_addr, 32'h4);
        chk("lit_inst0", IF_ID_inst, 32'h20010005);
        chk("lit_opc", 32'(OPC), 32'h08);
        chk("lit_valid_rise", 32'(IF_ID_valid), 32'd1);
        cycle(1, 0, 2'b00, 0, 0);
        chk("lit_addr8", imem_addr, 32'h8);
        chk("lit_pc4_8", IF_ID_pc4, 32'h8);

        // Taken branch with same-cycle ack: word discarded, bubble, retarget
        cycle(1, 0, 2'b01, 32'h40, 0);
        chk("lit_br_bubble", 32'(IF_ID_valid), 32'd0);
        chk("lit_br_inst", IF_ID_inst, 32'h0);
        chk("lit_br_addr", imem_addr, 32'h40);

        // Jump while a slow request is pending
        cycle(1, 0, 2'b00, 0, 0);
        cycle(0, 0, 2'b10, 0, 32'h100);
        chk("lit_drop_addr", imem_addr, 32'h44);
        cycle(0, 0, 2'b01, 32'h200, 0);
        cycle(0, 0, 2'b01, 32'h200, 0);
        chk("lit_drop_hold", imem_addr, 32'h44);
        chk("lit_drop_req", 32'(imem_req), 32'd1);
        chk("lit_drop_bubble", 32'(IF_ID_valid), 32'd0);
        cycle(1, 0, 2'b00, 0, 0);
        chk("lit_jmp_addr", imem_addr, 32'h100);
        chk("lit_jmp_bubble", 32'(IF_ID_valid), 32'd0);

        // Stall while a word is acked, then release
        cycle(1, 0, 2'b00, 0, 0);
        cycle(1, 1, 2'b00, 0, 0);
        chk("lit_hold_req", 32'(imem_req), 32'd0);
        chk("lit_hold_pc4", IF_ID_pc4, 32'h104);
        cycle(0, 1, 2'b00, 0, 0);
        cycle(0, 1, 2'b00, 0, 0);
        chk("lit_hold_pc4b", IF_ID_pc4, 32'h104);
        cycle(0, 0, 2'b00, 0, 0);
        chk("lit_unhold_inst", IF_ID_inst, 32'hA1C31E0E);
        chk("lit_unhold_pc4", IF_ID_pc4, 32'h108);
        chk("lit_unhold_addr", imem_addr, 32'h108);

        // Stall masks a redirect; redirect taken after release discards the buffer
        cycle(1, 1, 2'b01, 32'h80, 0);
        chk("lit_stall_noredir", IF_ID_pc4, 32'h108);
        cycle(0, 0, 2'b01, 32'h80, 0);
        chk("lit_late_redir_v", 32'(IF_ID_valid), 32'd0);
        chk("lit_late_redir_a", imem_addr, 32'h80);

        // PC wrap at the top of the address space, then reset mid-request
        cycle(1, 0, 2'b00, 0, 0);
        cycle(0, 0, 2'b10, 0, 32'hFFFFFFFC);
        cycle(1, 0, 2'b00, 0, 0);
        chk("lit_top_addr", imem_addr, 32'hFFFFFFFC);
        cycle(1, 0, 2'b00, 0, 0);
        chk("lit_wrap_addr", imem_addr, 32'h0);
        chk("lit_wrap_pc4", IF_ID_pc4, 32'h0);
        cycle(0, 0, 2'b00, 0, 0);
        do_reset();
        cycle(1, 0, 2'b00, 0, 0);
        chk("lit_rst_addr", imem_addr, RPC);
        chk("lit_rst_valid", 32'(IF_ID_valid), 32'd0);
        chk("lit_rst_req", 32'(imem_req), 32'd1);

        // Randomized traffic
        lat_on = 0; lat = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
                lat_on = 0;
            end
            if (model_req()) begin
                if (!lat_on) begin
                    lat = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
                    lat_on = 1;
                end
                if (lat == 0) begin r_ack = 1; lat_on = 0; end
                else begin r_ack = 0; lat--; end
            end else begin
                r_ack = ($urandom_range(0, 19) == 0);
                lat_on = 0;
            end
            r_st  = ($urandom_range(0, 9) < 3);
            r_src = 2'($urandom_range(0, 3));
            r_bt  = $urandom & 32'hFFFF_FFFC;
            r_jt  = $urandom;
            if ($urandom_range(0, 7) != 0) r_jt[1:0] = 2'b00;
            cycle(r_ack, r_st, r_src, r_bt, r_jt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
